// File: rtl/lsq_frame_driver.sv
// Initiator for the leastsquares strobe interface: buffers (a,b) pairs, sequences
// clear/accumulate/finish strobes, waits for done and presents the captured result.
module lsq_frame_driver #(
    parameter int unsigned N_PAIRS    = 100,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STROBE_GAP = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        i_clk_n,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_a,
    input  logic [31:0] i_in_b,
    output logic [31:0] o_lsq_a,
    output logic [31:0] o_lsq_b,
    output logic [1:0]  o_lsq_c,
    output logic        o_lsq_e,
    input  logic        i_lsq_d,
    input  logic [31:0] i_lsq_data,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_data,
    output logic        o_res_err,
    output logic        o_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(N_PAIRS + 1);
    localparam int unsigned GW = $clog2(STROBE_GAP + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] NP       = CW'(N_PAIRS);
    localparam logic [GW-1:0] GAP_LAST = GW'(STROBE_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] CMD_ACC = 2'd0;
    localparam logic [1:0] CMD_FIN = 2'd1;
    localparam logic [1:0] CMD_CLR = 2'd2;

    typedef enum logic [2:0] {
        StIdle, StClear, StFeed, StFinish, StWaitD, StCapture, StResult
    } state_e;

    typedef enum logic [1:0] {PhLoad, PhSetup, PhHigh, PhGap} phase_e;

    state_e        r_state, w_state_nxt;
    phase_e        r_ph, w_ph_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_to, w_to_nxt;
    logic          r_d_s1, r_d_s2;

    logic [31:0]   r_lsq_a, r_lsq_b, w_a_nxt, w_b_nxt;
    logic [1:0]    r_lsq_c, w_c_nxt;
    logic          r_lsq_e, w_e_nxt;
    logic          r_res_valid, w_rv_nxt;
    logic [31:0]   r_res_data, w_rd_nxt;
    logic          r_res_err, w_re_nxt;
    logic          r_busy;
    logic          r_in_ready;

    logic [31:0]   r_mem_a [FIFO_DEPTH];
    logic [31:0]   r_mem_b [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          w_push, w_pop, w_empty;

    assign w_push  = i_in_valid & r_in_ready;
    assign w_empty = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk_n) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= i_in_a;
            r_mem_b[r_wptr] <= i_in_b;
        end
    end

    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != FULL);
        end
    end

    // Each strobe: operands loaded, one setup cycle, e high one cycle, then the gap.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_gap_nxt   = r_gap;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to;
        w_a_nxt     = r_lsq_a;
        w_b_nxt     = r_lsq_b;
        w_c_nxt     = r_lsq_c;
        w_e_nxt     = 1'b0;
        w_rv_nxt    = r_res_valid;
        w_rd_nxt    = r_res_data;
        w_re_nxt    = r_res_err;
        w_pop       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_c_nxt = CMD_CLR;
                if (i_start) begin
                    w_state_nxt = StClear;
                    w_ph_nxt    = PhSetup;
                    w_cnt_nxt   = '0;
                end
            end
            StClear, StFeed, StFinish: begin
                unique case (r_ph)
                    PhLoad: begin
                        if (!w_empty) begin
                            w_pop    = 1'b1;
                            w_a_nxt  = r_mem_a[r_rptr];
                            w_b_nxt  = r_mem_b[r_rptr];
                            w_c_nxt  = CMD_ACC;
                            w_ph_nxt = PhSetup;
                        end
                    end
                    PhSetup: begin
                        w_e_nxt  = 1'b1;
                        w_ph_nxt = PhHigh;
                    end
                    PhHigh: begin
                        w_ph_nxt  = PhGap;
                        w_gap_nxt = '0;
                        if (r_state == StFeed) w_cnt_nxt = r_cnt + 1'b1;
                    end
                    PhGap: begin
                        if (r_gap != GAP_LAST) begin
                            w_gap_nxt = r_gap + 1'b1;
                        end else if (r_state == StClear) begin
                            w_state_nxt = StFeed;
                            w_ph_nxt    = PhLoad;
                        end else if (r_state == StFeed) begin
                            if (r_cnt == NP) begin
                                w_state_nxt = StFinish;
                                w_ph_nxt    = PhSetup;
                                w_c_nxt     = CMD_FIN;
                            end else begin
                                w_ph_nxt = PhLoad;
                            end
                        end else begin
                            w_state_nxt = StWaitD;
                            w_to_nxt    = '0;
                        end
                    end
                endcase
            end
            StWaitD: begin
                if (r_d_s2) begin
                    w_state_nxt = StCapture;
                end else if (r_to == TO_LAST) begin
                    w_state_nxt = StResult;
                    w_rv_nxt    = 1'b1;
                    w_rd_nxt    = '0;
                    w_re_nxt    = 1'b1;
                end else begin
                    w_to_nxt = r_to + 1'b1;
                end
            end
            StCapture: begin
                w_state_nxt = StResult;
                w_rv_nxt    = 1'b1;
                w_rd_nxt    = i_lsq_data;
                w_re_nxt    = 1'b0;
            end
            StResult: begin
                if (r_res_valid && i_res_ready) begin
                    w_state_nxt = StIdle;
                    w_rv_nxt    = 1'b0;
                    w_c_nxt     = CMD_CLR;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ph        <= PhSetup;
            r_gap       <= '0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_d_s1      <= 1'b0;
            r_d_s2      <= 1'b0;
            r_lsq_a     <= '0;
            r_lsq_b     <= '0;
            r_lsq_c     <= CMD_CLR;
            r_lsq_e     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ph        <= w_ph_nxt;
            r_gap       <= w_gap_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to        <= w_to_nxt;
            r_d_s1      <= i_lsq_d;
            r_d_s2      <= r_d_s1;
            r_lsq_a     <= w_a_nxt;
            r_lsq_b     <= w_b_nxt;
            r_lsq_c     <= w_c_nxt;
            r_lsq_e     <= w_e_nxt;
            r_res_valid <= w_rv_nxt;
            r_res_data  <= w_rd_nxt;
            r_res_err   <= w_re_nxt;
            r_busy      <= (w_state_nxt != StIdle);
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_lsq_a     = r_lsq_a;
    assign o_lsq_b     = r_lsq_b;
    assign o_lsq_c     = r_lsq_c;
    assign o_lsq_e     = r_lsq_e;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_err   = r_res_err;
    assign o_busy      = r_busy;

endmodule
